// File: rtl/data_mem_responder.sv
// Data-port memory responder: requests complete after WAIT_CYCLES wait states, then one RESP cycle pulses mem_ready.
// Processor holds its strobe until mem_ready; a strobe seen in IDLE is a new access, and inputs are ignored while busy.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        addr_fault,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_wait_cnt;
  logic [3:0]              w_wait_cnt_nxt;
  logic                    w_enter_resp;

  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [31:0]             r_wdata;
  logic                    r_is_write;
  logic                    r_fault;
  logic [31:0]             r_data_out;
  logic [31:0]             r_mem [DEPTH];

  logic                    w_req;
  logic                    w_capture;
  logic                    w_req_fault;
  logic [DEPTH_LOG2-1:0]   w_cur_idx;
  logic [31:0]             w_cur_wdata;
  logic                    w_cur_write;
  logic                    w_cur_fault;

  assign w_req       = mem_read | mem_write;
  assign w_capture   = (r_state == S_IDLE) && w_req;
  assign w_req_fault = (data_addr[1:0] != 2'b00) ||
                       (|data_addr[31:DEPTH_LOG2+2]) ||
                       (mem_read && mem_write);

  // With zero wait states the RAM access happens on the capture edge itself,
  // so the live request is used instead of the not-yet-captured registers.
  assign w_cur_idx   = (r_state == S_IDLE) ? data_addr[DEPTH_LOG2+1:2] : r_idx;
  assign w_cur_wdata = (r_state == S_IDLE) ? data_in     : r_wdata;
  assign w_cur_write = (r_state == S_IDLE) ? mem_write   : r_is_write;
  assign w_cur_fault = (r_state == S_IDLE) ? w_req_fault : r_fault;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_enter_resp   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wait_cnt_nxt = 4'd0;
        if (w_req) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == LAST_WAIT) begin
          w_state_nxt    = S_RESP;
          w_wait_cnt_nxt = 4'd0;
          w_enter_resp   = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_data_out <= 32'd0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_is_write <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_capture) begin
        r_idx      <= data_addr[DEPTH_LOG2+1:2];
        r_wdata    <= data_in;
        r_is_write <= mem_write;
        r_fault    <= w_req_fault;
      end
      if (w_enter_resp && !w_cur_fault && !w_cur_write)
        r_data_out <= r_mem[w_cur_idx];
      else
        r_data_out <= 32'd0;
    end
  end

  // RAM is never cleared; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && w_enter_resp && w_cur_write && !w_cur_fault)
      r_mem[w_cur_idx] <= w_cur_wdata;
  end

  assign mem_ready  = (r_state == S_RESP);
  assign addr_fault = (r_state == S_RESP) && r_fault;
  assign busy       = (r_state != S_IDLE);
  assign data_out   = r_data_out;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_addr, data_in;
  logic        mem_read, mem_write, mem_read0, mem_write0;
  logic [31:0] data_out, data_out0;
  logic        mem_ready, addr_fault, busy;
  logic        mem_ready0, addr_fault0, busy0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .data_in(data_in),
    .mem_read(mem_read), .mem_write(mem_write), .data_out(data_out),
    .mem_ready(mem_ready), .addr_fault(addr_fault), .busy(busy)
  );

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .data_in(data_in),
    .mem_read(mem_read0), .mem_write(mem_write0), .data_out(data_out0),
    .mem_ready(mem_ready0), .addr_fault(addr_fault0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drop_strobes();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_read0  = 1'b0;
    mem_write0 = 1'b0;
  endtask

  // Issues one access, holds the strobe until mem_ready (bounded), then releases it.
  task automatic access(input bit sel0, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit do_chg, input logic [31:0] chg,
                        output int lat, output logic [31:0] rdata,
                        output logic flt, output int bcyc);
    bit got;
    got   = 1'b0;
    lat   = -1;
    bcyc  = 0;
    rdata = 32'hxxxx_xxxx;
    flt   = 1'bx;
    @(negedge clk);
    data_addr = addr;
    data_in   = wdata;
    if (sel0) begin mem_read0 = rd; mem_write0 = wr; end
    else      begin mem_read  = rd; mem_write  = wr; end
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (do_chg) data_in = chg;
      if (sel0 ? busy0 : busy) bcyc++;
      if (sel0 ? mem_ready0 : mem_ready) begin
        got   = 1'b1;
        lat   = i;
        rdata = sel0 ? data_out0 : data_out;
        flt   = sel0 ? addr_fault0 : addr_fault;
        drop_strobes();
      end
    end
    if (!got) drop_strobes();
  endtask

  int          lat, bcyc, nready;
  logic [31:0] rdata;
  logic        flt;

  initial begin
    rst_n = 1'b0;
    data_addr = 32'd0;
    data_in   = 32'd0;
    drop_strobes();
    repeat (3) @(negedge clk);
    check("reset mem_ready", {31'd0, mem_ready}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset addr_fault", {31'd0, addr_fault}, 32'd0);
    check("reset data_out", data_out, 32'd0);
    check("reset busy0", {31'd0, busy0}, 32'd0);
    rst_n = 1'b1;

    // Write then read back, with latency and busy duration
    access(0, 0, 1, 32'h010, 32'hDEADBEEF, 0, 0, lat, rdata, flt, bcyc);
    check("wr010 latency", 32'(lat), 32'd3);
    check("wr010 busy cycles", 32'(bcyc), 32'd3);
    check("wr010 fault", {31'd0, flt}, 32'd0);
    check("wr010 data_out", rdata, 32'd0);
    access(0, 1, 0, 32'h010, 32'h0, 0, 0, lat, rdata, flt, bcyc);
    check("rd010 latency", 32'(lat), 32'd3);
    check("rd010 busy cycles", 32'(bcyc), 32'd3);
    check("rd010 data", rdata, 32'hDEADBEEF);
    check("rd010 fault", {31'd0, flt}, 32'd0);
    @(negedge clk);
    check("rd010 data_out after", data_out, 32'd0);
    check("rd010 busy after", {31'd0, busy}, 32'd0);

    // Misaligned and out-of-range reads
    access(0, 1, 0, 32'h012, 32'h0, 0, 0, lat, rdata, flt, bcyc);
    check("rd012 fault", {31'd0, flt}, 32'd1);
    check("rd012 data", rdata, 32'd0);
    check("rd012 latency", 32'(lat), 32'd3);
    access(0, 1, 0, 32'h400, 32'h0, 0, 0, lat, rdata, flt, bcyc);
    check("rd400 fault", {31'd0, flt}, 32'd1);
    check("rd400 data", rdata, 32'd0);
    access(0, 1, 0, 32'h010, 32'h0, 0, 0, lat, rdata, flt, bcyc);
    check("rd010 again", rdata, 32'hDEADBEEF);

    // Simultaneous read and write is rejected without touching RAM
    access(0, 0, 1, 32'h020, 32'hA5A5A5A5, 0, 0, lat, rdata, flt, bcyc);
    access(0, 1, 1, 32'h020, 32'h12345678, 0, 0, lat, rdata, flt, bcyc);
    check("rdwr020 fault", {31'd0, flt}, 32'd1);
    check("rdwr020 data_out", rdata, 32'd0);
    access(0, 1, 0, 32'h020, 32'h0, 0, 0, lat, rdata, flt, bcyc);
    check("rd020 unchanged", rdata, 32'hA5A5A5A5);

    // Data change during WAIT is ignored
    access(0, 0, 1, 32'h004, 32'h11111111, 1, 32'h22222222, lat, rdata, flt, bcyc);
    check("wr004 latency", 32'(lat), 32'd3);
    access(0, 1, 0, 32'h004, 32'h0, 0, 0, lat, rdata, flt, bcyc);
    check("rd004 captured data", rdata, 32'h11111111);

    // Reset on the commit edge of a write drops it
    access(0, 0, 1, 32'h008, 32'h55AA55AA, 0, 0, lat, rdata, flt, bcyc);
    @(negedge clk);
    data_addr = 32'h008;
    data_in   = 32'hCAFEF00D;
    mem_write = 1'b1;
    @(negedge clk);
    check("rstwr busy in wait", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("rstwr mem_ready", {31'd0, mem_ready}, 32'd0);
    check("rstwr busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    nready = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_ready) nready++;
    end
    check("rstwr late ready count", 32'(nready), 32'd0);
    access(0, 1, 0, 32'h008, 32'h0, 0, 0, lat, rdata, flt, bcyc);
    check("rd008 old value", rdata, 32'h55AA55AA);

    // Zero wait states: single-cycle latency and back-to-back reads
    access(1, 0, 1, 32'h000, 32'h00000001, 0, 0, lat, rdata, flt, bcyc);
    check("w0 wr000 latency", 32'(lat), 32'd1);
    check("w0 wr000 busy cycles", 32'(bcyc), 32'd1);
    access(1, 0, 1, 32'h004, 32'h00000002, 0, 0, lat, rdata, flt, bcyc);
    @(negedge clk);
    data_addr = 32'h000;
    mem_read0 = 1'b1;
    @(negedge clk);
    check("w0 b2b first ready", {31'd0, mem_ready0}, 32'd1);
    check("w0 b2b first data", data_out0, 32'h00000001);
    data_addr = 32'h004;
    @(negedge clk);
    check("w0 b2b gap ready", {31'd0, mem_ready0}, 32'd0);
    check("w0 b2b gap data_out", data_out0, 32'd0);
    @(negedge clk);
    check("w0 b2b second ready", {31'd0, mem_ready0}, 32'd1);
    check("w0 b2b second data", data_out0, 32'h00000002);
    mem_read0 = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
